kgp_ctrl_seq: RTL and testbench
===============================

Name: kgp_ctrl_seq

Overview:
- Multicycle control sequencer for the KGP-RISC core.
- Consumes the instruction decoder's opcode/fcode fields plus ALU flags, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives PC, IR, register-file, ALU-source and data-memory controls; handles instruction-ROM and data-memory ready handshakes with a timeout.
- Sits between the instruction ROM/decoder and the datapath.

Parameters:
TIMEOUT, 16, max wait cycles in FETCH or MEM before error halt; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  start execution from IDLE
opcode  in  3  decoder opcode field (inst[31:29])
fcode  in  4  decoder function field
flag_z  in  1  ALU zero flag, from EXEC of previous ALU op
flag_c  in  1  ALU carry flag
flag_s  in  1  ALU sign flag
instr_valid  in  1  instruction ROM data valid
mem_ready  in  1  data memory access complete
pc_we  out  1  PC load enable
pc_sel  out  2  00 PC+4, 01 branch target, 10 jump label
ir_we  out  1  instruction register load
rf_we  out  1  register-file write enable
rf_wsel  out  1  0 ALU result, 1 memory data
alu_src_imm  out  1  ALU B operand = sign-extended imm
alu_op  out  4  ALU function (fcode for R/I types, 0000 add for address calc)
mem_req  out  1  data memory request
mem_we  out  1  data memory write (valid with mem_req)
halted  out  1  in HALT state
err_illegal  out  1  sticky: illegal opcode seen
err_timeout  out  1  sticky: handshake timeout
retired  out  CNT_W  completed-instruction count

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; retired=0; wait counter=0; latched opcode/fcode=0.
- Opcode map:
  - 000: R-type ALU.
  - 001: I-type ALU.
  - 010: load/store; fcode[0]=0 load, 1 store.
  - 011: branch.
  - 100: jump.
  - 111: halt.
  - 101 and 110: illegal.
- Outputs: combinational from state, latched opcode/fcode, and flags. Opcode/fcode are latched in DECODE.
- IDLE: all controls 0. run=1 -> FETCH.
- FETCH:
  - Waits for instr_valid.
  - On instr_valid: ir_we=1, pc_we=1, pc_sel=00, go to DECODE.
  - Wait counter increments each cycle without instr_valid. Reaching TIMEOUT -> HALT, err_timeout=1.
- DECODE:
  - Latches opcode/fcode. No enables asserted.
  - opcode 111 -> HALT (retired +1).
  - Illegal opcode -> HALT, err_illegal=1, retired unchanged.
  - Otherwise -> EXEC.
- EXEC:
  - R-type: alu_op=fcode, alu_src_imm=0 -> WB.
  - I-type: alu_op=fcode, alu_src_imm=1 -> WB.
  - Load/store: alu_op=0000, alu_src_imm=1 -> MEM.
  - Branch:
    - Condition by fcode: 0 z, 1 !z, 2 c, 3 !c, 4 s, 5 !s, 6 always; 7-15 never.
    - If taken: pc_we=1, pc_sel=01.
    - -> FETCH, retired +1.
  - Jump: pc_we=1, pc_sel=10 -> FETCH, retired +1.
- MEM:
  - mem_req=1; mem_we=fcode[0]. Holds until mem_ready.
  - On mem_ready: load -> WB; store -> FETCH, retired +1.
  - Timeout identical to FETCH.
- WB: rf_we=1; rf_wsel=1 for load, else 0. -> FETCH, retired +1.
- HALT: absorbing; all enables 0; halted=1. Only rst exits.
- Wait counter: cleared on every state change. A ready arriving in the same cycle the count hits TIMEOUT is accepted, not an error.
- CPI with zero-wait memories: ALU 4, load 5, store 4, branch/jump 3.
- retired wraps modulo 2^CNT_W.
- run is ignored outside IDLE. Dropping run mid-instruction does not stop execution.
- rst mid-MEM drops mem_req asynchronously.

Decomposition:
- Shared package kgp_pkg holds:
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LDST, OP_BR, OP_JMP, OP_HALT;
  - branch-condition codes;
  - state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - PC_SEL constants.
- One natural sub-module: kgp_br_cond, combinational evaluation of branch-taken from fcode and flags.

Test Plan:
- R-type, zero-wait: run=1, opcode=000, fcode=0101, instr_valid/mem_ready held 1 -> ir_we at cycle 1; alu_op=0101 in EXEC; rf_we=1, rf_wsel=0 in WB; retired=1 after 4 cycles.
- Load with 3-cycle mem_ready delay: opcode=010, fcode=0000 -> mem_req=1, mem_we=0 for 3 cycles; WB rf_wsel=1; retired=1 after 8 cycles.
- Branch: opcode=011, fcode=0000.
  - flag_z=1 -> pc_we=1, pc_sel=01 in EXEC.
  - Repeat with flag_z=0 -> pc_we=0 in EXEC; both return to FETCH.
- Timeout: TIMEOUT=16, instr_valid held 0 -> halted=1, err_timeout=1 after 16 FETCH cycles; further run/valid ignored until rst.
- Illegal and halt:
  - opcode=101 -> HALT, err_illegal=1, retired unchanged.
  - After rst, opcode=111 -> halted=1, err_illegal=0, retired=1.
- Async reset mid-MEM: assert rst while mem_req=1 -> mem_req=0 and state=IDLE before the next clock edge; retired=0.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared constants and types for the KGP-RISC control sequencer.
package kgp_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ITYPE = 3'b001;
    localparam logic [2:0] OP_LDST  = 3'b010;
    localparam logic [2:0] OP_BR    = 3'b011;
    localparam logic [2:0] OP_JMP   = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [3:0] BC_Z   = 4'd0;
    localparam logic [3:0] BC_NZ  = 4'd1;
    localparam logic [3:0] BC_C   = 4'd2;
    localparam logic [3:0] BC_NC  = 4'd3;
    localparam logic [3:0] BC_S   = 4'd4;
    localparam logic [3:0] BC_NS  = 4'd5;
    localparam logic [3:0] BC_AL  = 4'd6;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // 101 and 110 are the only unassigned opcodes.
    function automatic logic op_legal(input logic [2:0] op);
        return !((op == 3'b101) || (op == 3'b110));
    endfunction

endpackage

// File: rtl/kgp_br_cond.sv
// Branch-taken evaluation from the branch function code and ALU flags.
module kgp_br_cond
    import kgp_pkg::*;
(
    input  logic [3:0] fcode,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_s,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (fcode)
            BC_Z:    taken = flag_z;
            BC_NZ:   taken = !flag_z;
            BC_C:    taken = flag_c;
            BC_NC:   taken = !flag_c;
            BC_S:    taken = flag_s;
            BC_NS:   taken = !flag_s;
            BC_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/kgp_ctrl_seq.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the KGP-RISC core.
// state  | meaning
// IDLE   | waiting for run
// FETCH  | waiting for instr_valid; loads IR and PC+4
// DECODE | latches opcode/fcode, screens halt/illegal
// EXEC   | ALU control, branch/jump resolution
// MEM    | data memory access until mem_ready
// WB     | register-file write
// HALT   | absorbing until rst
module kgp_ctrl_seq
    import kgp_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [2:0]       opcode,
    input  logic [3:0]       fcode,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             flag_s,
    input  logic             instr_valid,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ir_we,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             alu_src_imm,
    output logic [3:0]       alu_op,
    output logic             mem_req,
    output logic             mem_we,
    output logic             halted,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [2:0]         opcode_q, opcode_d;
    logic [3:0]         fcode_q, fcode_d;
    logic               err_il_q, err_il_d;
    logic               err_to_q, err_to_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic               br_taken;
    logic               timed_out;

    kgp_br_cond u_br_cond (
        .fcode  (fcode_q),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_s (flag_s),
        .taken  (br_taken)
    );

    // The cycle that would reach TIMEOUT still honours a ready seen in it.
    assign timed_out = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        opcode_d    = opcode_q;
        fcode_d     = fcode_q;
        err_il_d    = err_il_q;
        err_to_d    = err_to_q;
        retire      = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_SEL_INC;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        rf_wsel     = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timed_out) begin
                    state_d  = ST_HALT;
                    err_to_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DECODE: begin
                opcode_d = opcode;
                fcode_d  = fcode;
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end else if (!op_legal(opcode)) begin
                    state_d  = ST_HALT;
                    err_il_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode_q)
                    OP_RTYPE: begin
                        alu_op  = fcode_q;
                        state_d = ST_WB;
                    end
                    OP_ITYPE: begin
                        alu_op      = fcode_q;
                        alu_src_imm = 1'b1;
                        state_d     = ST_WB;
                    end
                    OP_LDST: begin
                        alu_src_imm = 1'b1;
                        state_d     = ST_MEM;
                    end
                    OP_BR: begin
                        if (br_taken) begin
                            pc_we  = 1'b1;
                            pc_sel = PC_SEL_BR;
                        end
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_JMP: begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_SEL_JMP;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        state_d  = ST_HALT;
                        err_il_d = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = fcode_q[0];
                if (mem_ready) begin
                    if (fcode_q[0]) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timed_out) begin
                    state_d  = ST_HALT;
                    err_to_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                rf_wsel = (opcode_q == OP_LDST);
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            opcode_q  <= '0;
            fcode_q   <= '0;
            err_il_q  <= 1'b0;
            err_to_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            opcode_q  <= opcode_d;
            fcode_q   <= fcode_d;
            err_il_q  <= err_il_d;
            err_to_q  <= err_to_d;
            retired_q <= retired_d;
        end
    end

    assign err_illegal = err_il_q;
    assign err_timeout = err_to_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_kgp_ctrl_seq.sv
// Scoreboard bench for kgp_ctrl_seq: driver queues per-cycle expected outputs, monitor compares on negedge.
module tb_kgp_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [2:0]  opcode = '0;
    logic [3:0]  fcode = '0;
    logic        flag_z = 1'b0, flag_c = 1'b0, flag_s = 1'b0;
    logic        instr_valid = 1'b0, mem_ready = 1'b0;

    logic        pc_we, ir_we, rf_we, rf_wsel, alu_src_imm, mem_req, mem_we;
    logic        halted, err_illegal, err_timeout;
    logic [1:0]  pc_sel;
    logic [3:0]  alu_op;
    logic [31:0] retired;

    kgp_ctrl_seq #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .fcode(fcode),
        .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s),
        .instr_valid(instr_valid), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .rf_we(rf_we),
        .rf_wsel(rf_wsel), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
        .err_illegal(err_illegal), .err_timeout(err_timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        ir_we;
        logic        rf_we;
        logic        rf_wsel;
        logic        alu_src_imm;
        logic [3:0]  alu_op;
        logic        mem_req;
        logic        mem_we;
        logic        halted;
        logic        err_il;
        logic        err_to;
        logic [31:0] retired;
    } outv_t;

    typedef struct {
        string nm;
        outv_t v;
    } exp_t;

    exp_t  sb[$];
    exp_t  cur;
    outv_t act;
    outv_t base;
    int    checks = 0;
    int    errors = 0;

    assign act = {pc_we, pc_sel, ir_we, rf_we, rf_wsel, alu_src_imm, alu_op,
                  mem_req, mem_we, halted, err_illegal, err_timeout, retired};

    // Expected outputs per state, layered on the sticky flags/retired count in base.
    function automatic outv_t o_none();
        return base;
    endfunction
    function automatic outv_t o_fetch();
        outv_t v = base; v.pc_we = 1'b1; v.ir_we = 1'b1; return v;
    endfunction
    function automatic outv_t o_alu(input logic [3:0] op, input logic imm);
        outv_t v = base; v.alu_op = op; v.alu_src_imm = imm; return v;
    endfunction
    function automatic outv_t o_mem(input logic we);
        outv_t v = base; v.mem_req = 1'b1; v.mem_we = we; return v;
    endfunction
    function automatic outv_t o_wb(input logic ld);
        outv_t v = base; v.rf_we = 1'b1; v.rf_wsel = ld; return v;
    endfunction
    function automatic outv_t o_br(input logic taken);
        outv_t v = base; v.pc_we = taken; v.pc_sel = taken ? 2'b01 : 2'b00; return v;
    endfunction
    function automatic outv_t o_jmp();
        outv_t v = base; v.pc_we = 1'b1; v.pc_sel = 2'b10; return v;
    endfunction
    function automatic outv_t o_halt();
        outv_t v = base; v.halted = 1'b1; return v;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                checks++;
                if (act !== cur.v) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", cur.nm, act, cur.v, $time);
                end
            end
        end
    end

    task automatic cyc(input string nm, input outv_t v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
        opcode = '0; fcode = '0; flag_z = 1'b0; flag_c = 1'b0; flag_s = 1'b0;
        base = '0;
        cyc("reset", o_none());
        rst = 1'b0;
    endtask

    task automatic start(input string nm, input logic [2:0] op, input logic [3:0] fc);
        do_reset();
        run = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1; opcode = op; fcode = fc;
        cyc({nm, " idle"}, o_none());
        cyc({nm, " fetch"}, o_fetch());
        cyc({nm, " decode"}, o_none());
    endtask

    task automatic br_instr(input string nm, input logic [2:0] op, input logic [3:0] fc,
                            input logic z, input logic c, input logic s, input logic taken);
        opcode = op; fcode = fc;
        flag_z = !z; flag_c = !c; flag_s = !s;
        cyc({nm, " fetch"}, o_fetch());
        cyc({nm, " decode"}, o_none());
        flag_z = z; flag_c = c; flag_s = s;
        cyc({nm, " exec"}, (op == 3'b100) ? o_jmp() : o_br(taken));
        base.retired = base.retired + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        base = '0;
        @(posedge clk);
        #1;

        // R-type, zero wait; opcode/fcode inputs change after DECODE to check latching
        do_reset();
        cyc("idle hold", o_none());
        run = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1; opcode = 3'b000; fcode = 4'b0101;
        cyc("r idle", o_none());
        cyc("r fetch", o_fetch());
        cyc("r decode", o_none());
        opcode = 3'b111; fcode = 4'b1111;
        cyc("r exec", o_alu(4'b0101, 1'b0));
        cyc("r wb", o_wb(1'b0));
        base.retired = 1;
        cyc("r next fetch", o_fetch());

        // I-type
        start("i", 3'b001, 4'b0011);
        opcode = 3'b000; fcode = 4'b0000;
        cyc("i exec", o_alu(4'b0011, 1'b1));
        cyc("i wb", o_wb(1'b0));
        base.retired = 1;
        cyc("i next fetch", o_fetch());

        // Load with 3-cycle memory delay
        start("ld", 3'b010, 4'b0000);
        mem_ready = 1'b0;
        cyc("ld exec", o_alu(4'b0000, 1'b1));
        for (int i = 0; i < 3; i++) cyc("ld mem wait", o_mem(1'b0));
        mem_ready = 1'b1;
        cyc("ld mem done", o_mem(1'b0));
        cyc("ld wb", o_wb(1'b1));
        base.retired = 1;
        cyc("ld next fetch", o_fetch());

        // Store, zero wait
        start("st", 3'b010, 4'b0001);
        cyc("st exec", o_alu(4'b0000, 1'b1));
        cyc("st mem", o_mem(1'b1));
        base.retired = 1;
        cyc("st next fetch", o_fetch());

        // Chained branches and a jump
        do_reset();
        run = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1;
        cyc("br idle", o_none());
        br_instr("br z taken",   3'b011, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        br_instr("br z not",     3'b011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        br_instr("br nz",        3'b011, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1);
        br_instr("br c not",     3'b011, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0);
        br_instr("br nc",        3'b011, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
        br_instr("br s",         3'b011, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1);
        br_instr("br ns not",    3'b011, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b0);
        br_instr("br always",    3'b011, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
        br_instr("br never",     3'b011, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b0);
        br_instr("jmp",          3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("br end fetch", o_fetch());

        // FETCH timeout, then halt ignores run/valid
        do_reset();
        run = 1'b1;
        cyc("to idle", o_none());
        for (int i = 0; i < 16; i++) cyc("to fetch wait", o_none());
        base.err_to = 1'b1;
        cyc("to halt", o_halt());
        instr_valid = 1'b1; mem_ready = 1'b1;
        cyc("to halt hold", o_halt());
        cyc("to halt hold2", o_halt());

        // instr_valid on the last allowed cycle is accepted
        do_reset();
        run = 1'b1; opcode = 3'b000; fcode = 4'b0010;
        cyc("edge idle", o_none());
        for (int i = 0; i < 15; i++) cyc("edge fetch wait", o_none());
        instr_valid = 1'b1;
        cyc("edge accept", o_fetch());
        cyc("edge decode", o_none());
        cyc("edge exec", o_alu(4'b0010, 1'b0));

        // MEM timeout on a store
        start("mto", 3'b010, 4'b0001);
        mem_ready = 1'b0;
        cyc("mto exec", o_alu(4'b0000, 1'b1));
        for (int i = 0; i < 16; i++) cyc("mto mem wait", o_mem(1'b1));
        base.err_to = 1'b1;
        cyc("mto halt", o_halt());

        // Illegal opcodes
        start("ill101", 3'b101, 4'b0000);
        base.err_il = 1'b1;
        cyc("ill101 halt", o_halt());
        cyc("ill101 hold", o_halt());
        start("ill110", 3'b110, 4'b0000);
        base.err_il = 1'b1;
        cyc("ill110 halt", o_halt());

        // Halt opcode retires
        start("hlt", 3'b111, 4'b0000);
        base.retired = 1;
        cyc("hlt halt", o_halt());
        cyc("hlt hold", o_halt());

        // Async reset while mem_req is high
        start("ar", 3'b010, 4'b0000);
        mem_ready = 1'b0;
        cyc("ar exec", o_alu(4'b0000, 1'b1));
        cyc("ar mem", o_mem(1'b0));
        #2;
        rst = 1'b1;
        base = '0;
        cyc("ar async", o_none());
        rst = 1'b0; run = 1'b0;
        cyc("ar idle after", o_none());

        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
